// File: rtl/result_bank.sv
// result_bank: collects a row_w x col_x matrix of MAC results (one row per
// beat on three 10-bit lanes) into a 9-entry buffer, then streams it out one
// element at a time under a valid/ready handshake.
// Build option: define RES_TRANSPOSE_EN for column-major drain order;
// without it the drain order is row-major.
module result_bank (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       start,
   input  logic [1:0] row_w,
   input  logic [1:0] col_x,
   input  logic [9:0] res_in1,
   input  logic [9:0] res_in2,
   input  logic [9:0] res_in3,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [9:0] data_out,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       done,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_rows;
   logic [1:0] r_cols;
   logic [1:0] r_row_cnt;
   logic [1:0] r_dr;
   logic [1:0] r_dc;
   logic       r_done;
   logic [9:0] r_buf [0:8];

   logic       w_start_ok;
   logic       w_beat;
   logic       w_accept;
   logic       w_last_row;
   logic       w_last_elem;
   logic [3:0] w_wr_base;
   logic [3:0] w_rd_idx;
   logic [9:0] w_lane [0:2];

   // Handshake qualifiers, terminal-count detection and buffer addressing
   always_comb begin
      w_start_ok  = start && (row_w != '0) && (col_x != '0);
      w_beat      = (r_state == COLLECT) && in_valid;
      w_accept    = (r_state == DRAIN) && out_ready;
      w_last_row  = (r_row_cnt == r_rows - 2'd1);
      w_last_elem = (r_dr == r_rows - 2'd1) && (r_dc == r_cols - 2'd1);
      w_wr_base   = {2'b00, r_row_cnt} * 4'd3;
      w_rd_idx    = ({2'b00, r_dr} * 4'd3) + {2'b00, r_dc};
      w_lane[0]   = res_in1;
      w_lane[1]   = res_in2;
      w_lane[2]   = res_in3;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!clear_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state decode and state-derived handshake outputs
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start_ok) w_next = COLLECT;
         end
         COLLECT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (w_beat && w_last_row) w_next = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (w_accept && w_last_elem) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Dimension latch, row/element counters (saturating) and done pulse
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         r_rows    <= '0;
         r_cols    <= '0;
         r_row_cnt <= '0;
         r_dr      <= '0;
         r_dc      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_accept && w_last_elem;
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  r_rows    <= row_w;
                  r_cols    <= col_x;
                  r_row_cnt <= '0;
                  r_dr      <= '0;
                  r_dc      <= '0;
               end
            end
            COLLECT: begin
               if (w_beat && !w_last_row) r_row_cnt <= r_row_cnt + 2'd1;
            end
            DRAIN: begin
               if (w_accept && !w_last_elem) begin
`ifdef RES_TRANSPOSE_EN
                  if (r_dr == r_rows - 2'd1) begin
                     r_dr <= '0;
                     r_dc <= r_dc + 2'd1;
                  end else begin
                     r_dr <= r_dr + 2'd1;
                  end
`else
                  if (r_dc == r_cols - 2'd1) begin
                     r_dc <= '0;
                     r_dr <= r_dr + 2'd1;
                  end else begin
                     r_dc <= r_dc + 2'd1;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // Result buffer: only lanes inside the latched width are written
   always_ff @(posedge clk) begin
      if (w_beat) begin
         for (int unsigned c = 0; c < 3; c++) begin
            if (c < 32'(r_cols)) r_buf[w_wr_base + 4'(c)] <= w_lane[2'(c)];
         end
      end
   end

   // Output element, forced to zero whenever it is not valid
   always_comb begin
      data_out = '0;
      done     = r_done;
      if (r_state == DRAIN) data_out = r_buf[w_rd_idx];
   end

endmodule

// File: tb/tb_result_bank.sv
// tb_result_bank: randomized self-checking bench for result_bank. The
// reference model orders the loaded matrix with plain nested loops; define
// RES_TRANSPOSE_EN for both bench and design to check column-major drain.
module tb_result_bank;

   logic       clk = 1'b0;
   logic       clear_n, start, in_valid, out_ready;
   logic [1:0] row_w, col_x;
   logic [9:0] res_in1, res_in2, res_in3;
   logic       in_ready, out_valid, done, busy;
   logic [9:0] data_out;

   result_bank dut (
      .clk(clk), .clear_n(clear_n), .start(start), .row_w(row_w), .col_x(col_x),
      .res_in1(res_in1), .res_in2(res_in2), .res_in3(res_in3),
      .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
      .out_valid(out_valid), .out_ready(out_ready), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   logic [9:0] mat [9];
   logic [9:0] exp_q [$];
   logic [9:0] got_q [$];
   int lat_obs, done_cnt, done_n, timed_out, proto_bad, done_bad;

   // Reference: expected drain sequence of the matrix loaded in mat
   function automatic void build_exp(input int rows, input int cols);
      exp_q.delete();
`ifdef RES_TRANSPOSE_EN
      for (int c = 0; c < cols; c++)
         for (int r = 0; r < rows; r++) exp_q.push_back(mat[3*r+c]);
`else
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) exp_q.push_back(mat[3*r+c]);
`endif
   endfunction

   // Stimulus driver: start, load rows from mat, drain with the chosen
   // out_ready pattern (0 always, 1 toggle, 2 random) and record observations.
   task automatic drive_matrix(input int rows, input int cols, input int bp,
                               input int noise, input int skip_start,
                               input int chain, input int nrows, input int ncols);
      int r, budget, n, finished;
      logic prev_hold;
      logic [9:0] prev_d;
      got_q.delete();
      lat_obs = -1; done_cnt = 0; done_n = -1; timed_out = 0; proto_bad = 0; done_bad = 0;
      if (skip_start == 0) begin
         @(negedge clk);
         start = 1'b1; row_w = 2'(rows); col_x = 2'(cols);
      end
      @(negedge clk);
      start = 1'b0;
      r = 0; budget = 0;
      while (r < rows && budget < 50) begin
         in_valid = (noise != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
         res_in1 = mat[3*r]; res_in2 = mat[3*r+1]; res_in3 = mat[3*r+2];
         if (noise != 0) begin
            start = 1'($urandom); row_w = 2'($urandom); col_x = 2'($urandom);
         end
         if (!out_valid && data_out !== 10'd0) proto_bad++;
         if (in_valid && in_ready) r++;
         budget++;
         @(negedge clk);
      end
      if (r < rows) timed_out = 1;
      in_valid = 1'b0; start = 1'b0; row_w = 2'(rows); col_x = 2'(cols);
      n = 1; finished = 0; prev_hold = 1'b0; prev_d = '0; budget = 0;
      while (finished == 0 && budget < 200) begin
         if (done) begin
            finished = 1; done_cnt++; done_n = n;
            if (out_valid || busy || data_out !== 10'd0) done_bad++;
         end else begin
            if (out_valid && lat_obs < 0) lat_obs = n;
            if (prev_hold && (!out_valid || data_out !== prev_d)) proto_bad++;
            if (!out_valid && data_out !== 10'd0) proto_bad++;
            case (bp)
               0:       out_ready = 1'b1;
               1:       out_ready = 1'(n);
               default: out_ready = 1'($urandom);
            endcase
            if (noise != 0) begin
               in_valid = 1'($urandom);
               res_in1 = 10'($urandom); res_in2 = 10'($urandom); res_in3 = 10'($urandom);
            end
            if (out_valid && out_ready) got_q.push_back(data_out);
            prev_hold = out_valid && !out_ready; prev_d = data_out;
            @(negedge clk);
            n++; budget++;
         end
      end
      if (finished == 0) timed_out = 1;
      in_valid = 1'b0; out_ready = 1'b1;
      if (chain != 0) begin
         start = 1'b1; row_w = 2'(nrows); col_x = 2'(ncols);
      end else if (finished != 0) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
   endtask

   task automatic test_reset();
      clear_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      row_w = '0; col_x = '0; res_in1 = '0; res_in2 = '0; res_in3 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
      vecs++; if (data_out !== 10'd0) begin errs++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
      clear_n = 1'b1;
   endtask

   task automatic test_3x3();
      for (int i = 0; i < 9; i++) mat[i] = 10'(i + 1);
      build_exp(3, 3);
      drive_matrix(3, 3, 0, 0, 0, 0, 0, 0);
      vecs++; if (timed_out !== 0) begin errs++; $display("FAIL 3x3_timeout got=%0d exp=0", timed_out); end
      vecs++; if (got_q.size() != 9) begin errs++; $display("FAIL 3x3_count got=%0d exp=9", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         vecs++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errs++; $display("FAIL 3x3_elem%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 10'd0, exp_q[i]);
         end
      end
      vecs++; if (lat_obs != 1) begin errs++; $display("FAIL 3x3_latency got=%0d exp=1", lat_obs); end
      vecs++; if (done_n != 10) begin errs++; $display("FAIL 3x3_done_cycle got=%0d exp=10", done_n); end
      vecs++; if (done_cnt != 1) begin errs++; $display("FAIL 3x3_done_pulses got=%0d exp=1", done_cnt); end
      vecs++; if (done_bad != 0) begin errs++; $display("FAIL 3x3_done_state got=%0d exp=0", done_bad); end
   endtask

   task automatic test_shapes();
      for (int i = 0; i < 9; i++) mat[i] = 10'd1000;
      mat[0] = 10'd10; mat[3] = 10'd20;
      drive_matrix(2, 1, 0, 0, 0, 0, 0, 0);
      vecs++; if (got_q.size() != 2) begin errs++; $display("FAIL 2x1_count got=%0d exp=2", got_q.size()); end
      vecs++; if (got_q.size() < 1 || got_q[0] !== 10'd10) begin errs++; $display("FAIL 2x1_first got=%0d exp=10", (got_q.size() > 0) ? got_q[0] : 10'd0); end
      vecs++; if (got_q.size() < 2 || got_q[1] !== 10'd20) begin errs++; $display("FAIL 2x1_second got=%0d exp=20", (got_q.size() > 1) ? got_q[1] : 10'd0); end
      for (int i = 0; i < 9; i++) mat[i] = 10'd900;
      mat[0] = 10'd1; mat[1] = 10'd2; mat[2] = 10'd3; mat[3] = 10'd4; mat[4] = 10'd5; mat[5] = 10'd6;
      build_exp(2, 3);
      drive_matrix(2, 3, 0, 0, 0, 0, 0, 0);
      vecs++; if (got_q.size() != 6) begin errs++; $display("FAIL 2x3_count got=%0d exp=6", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         vecs++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errs++; $display("FAIL 2x3_elem%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 10'd0, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int mode = 1; mode <= 2; mode++) begin
         for (int i = 0; i < 9; i++) mat[i] = 10'($urandom);
         build_exp(3, 3);
         drive_matrix(3, 3, mode, 0, 0, 0, 0, 0);
         vecs++; if (timed_out !== 0) begin errs++; $display("FAIL bp%0d_timeout got=%0d exp=0", mode, timed_out); end
         vecs++; if (proto_bad != 0) begin errs++; $display("FAIL bp%0d_hold got=%0d exp=0", mode, proto_bad); end
         vecs++; if (got_q.size() != 9) begin errs++; $display("FAIL bp%0d_count got=%0d exp=9", mode, got_q.size()); end
         for (int i = 0; i < exp_q.size(); i++) begin
            vecs++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               errs++; $display("FAIL bp%0d_elem%0d got=%0d exp=%0d", mode, i, (i < got_q.size()) ? got_q[i] : 10'd0, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_ignored();
      @(negedge clk);
      start = 1'b1; row_w = 2'd2; col_x = 2'd0;
      @(negedge clk);
      start = 1'b0;
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ign_colx0_busy got=%b exp=0", busy); end
      start = 1'b1; row_w = 2'd0; col_x = 2'd3;
      @(negedge clk);
      start = 1'b0;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL ign_roww0_in_ready got=%b exp=0", in_ready); end
      for (int i = 0; i < 9; i++) mat[i] = 10'($urandom);
      build_exp(2, 2);
      drive_matrix(2, 2, 2, 1, 0, 0, 0, 0);
      vecs++; if (timed_out !== 0) begin errs++; $display("FAIL ign_noise_timeout got=%0d exp=0", timed_out); end
      vecs++; if (got_q.size() != 4) begin errs++; $display("FAIL ign_noise_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         vecs++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errs++; $display("FAIL ign_noise_elem%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 10'd0, exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 9; i++) mat[i] = 10'($urandom);
      build_exp(2, 2);
      drive_matrix(2, 2, 0, 0, 0, 1, 1, 3);
      vecs++; if (done_cnt != 1) begin errs++; $display("FAIL b2b_first_done got=%0d exp=1", done_cnt); end
      vecs++; if (got_q.size() != 4 || got_q[3] !== exp_q[3]) begin errs++; $display("FAIL b2b_first_last got=%0d exp=%0d", (got_q.size() > 3) ? got_q[3] : 10'd0, exp_q[3]); end
      for (int i = 0; i < 9; i++) mat[i] = 10'($urandom);
      build_exp(1, 3);
      drive_matrix(1, 3, 0, 0, 1, 0, 0, 0);
      vecs++; if (timed_out !== 0) begin errs++; $display("FAIL b2b_second_timeout got=%0d exp=0", timed_out); end
      vecs++; if (got_q.size() != 3) begin errs++; $display("FAIL b2b_second_count got=%0d exp=3", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         vecs++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            errs++; $display("FAIL b2b_second_elem%0d got=%0d exp=%0d", i, (i < got_q.size()) ? got_q[i] : 10'd0, exp_q[i]);
         end
      end
   endtask

   task automatic test_midreset();
      @(negedge clk);
      start = 1'b1; row_w = 2'd3; col_x = 2'd3;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1;
      res_in1 = 10'd11; res_in2 = 10'd12; res_in3 = 10'd13;
      @(negedge clk);
      res_in1 = 10'd21; res_in2 = 10'd22; res_in3 = 10'd23;
      @(negedge clk);
      in_valid = 1'b0; clear_n = 1'b0;
      @(negedge clk);
      clear_n = 1'b1;
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      vecs++; if (done !== 1'b0) begin errs++; $display("FAIL midrst_done got=%b exp=0", done); end
      @(negedge clk);
      vecs++; if (done !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL midrst_after done=%b in_ready=%b exp=0,0", done, in_ready); end
      for (int i = 0; i < 9; i++) mat[i] = 10'd77;
      mat[0] = 10'd511;
      drive_matrix(1, 1, 0, 0, 0, 0, 0, 0);
      vecs++; if (got_q.size() != 1 || got_q[0] !== 10'd511) begin errs++; $display("FAIL midrst_1x1 got=%0d exp=511", (got_q.size() > 0) ? got_q[0] : 10'd0); end
      vecs++; if (done_cnt != 1) begin errs++; $display("FAIL midrst_1x1_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_random();
      int rows, cols;
      for (int t = 0; t < 20; t++) begin
         rows = $urandom_range(1, 3); cols = $urandom_range(1, 3);
         for (int i = 0; i < 9; i++) mat[i] = 10'($urandom);
         build_exp(rows, cols);
         drive_matrix(rows, cols, 2, t % 2, 0, 0, 0, 0);
         vecs++;
         if (timed_out !== 0 || proto_bad != 0 || done_cnt != 1 || got_q.size() != exp_q.size()) begin
            errs++; $display("FAIL rand%0d_proto timeout=%0d hold=%0d done=%0d count=%0d exp=0,0,1,%0d",
                             t, timed_out, proto_bad, done_cnt, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            vecs++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               errs++; $display("FAIL rand%0d_elem%0d got=%0d exp=%0d", t, i, (i < got_q.size()) ? got_q[i] : 10'd0, exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_3x3();
      test_shapes();
      test_backpressure();
      test_ignored();
      test_back_to_back();
      test_midreset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
